// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for one MAC array instance.
// Accepts a command (base, length, tag), issues consecutive operand-buffer
// reads, drives the array enable/clear strobes aligned to read-data return,
// waits for the array pipeline to drain and presents a tagged result.
module mac_seq_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int LEN_WIDTH    = 8,
  parameter int TAG_WIDTH    = 4,
  parameter int RD_LATENCY   = 1,
  parameter int PIPE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  array_enable,
  output logic                  array_clear,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [TAG_WIDTH-1:0]  res_tag,
  output logic                  busy,
  output logic                  err_zero_len,
  output logic [15:0]           done_cnt
);

  // Cycles spent in DRAIN so the result appears PIPE_LATENCY cycles after
  // the last array enable (which itself trails the last read by RD_LATENCY).
  localparam int DRAIN_CYC = RD_LATENCY + PIPE_LATENCY - 1;
  localparam int DW        = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);
  localparam logic [DW-1:0]        DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_cmd_ready;
  logic                    r_rd_en;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_beat;      // index of the beat currently on rd_en
  logic [DW-1:0]           r_drain;
  logic                    r_res_valid;
  logic [TAG_WIDTH-1:0]    r_res_tag;
  logic                    r_busy;
  logic                    r_err_zero_len;
  logic [15:0]             r_done_cnt;
  logic [RD_LATENCY-1:0]   r_en_dly;
  logic [RD_LATENCY-1:0]   r_clr_dly;

  logic w_cmd_fire;
  logic w_flush;
  logic w_first_beat;
  logic w_last_beat;

  assign w_cmd_fire   = cmd_valid & r_cmd_ready;
  // abort only acts while a command is in flight
  assign w_flush      = abort & (r_state != S_IDLE);
  assign w_first_beat = (r_state == S_ISSUE) & (r_beat == {LEN_WIDTH{1'b0}});
  // r_len is never zero while in ISSUE, so len-1 cannot underflow
  assign w_last_beat  = (r_beat == (r_len - LEN_ONE));

  // Main sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cmd_ready    <= 1'b1;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= {ADDR_WIDTH{1'b0}};
      r_len          <= {LEN_WIDTH{1'b0}};
      r_beat         <= {LEN_WIDTH{1'b0}};
      r_drain        <= {DW{1'b0}};
      r_res_valid    <= 1'b0;
      r_res_tag      <= {TAG_WIDTH{1'b0}};
      r_busy         <= 1'b0;
      r_err_zero_len <= 1'b0;
      r_done_cnt     <= 16'd0;
    end else begin
      r_err_zero_len <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            if (cmd_len == {LEN_WIDTH{1'b0}}) begin
              r_err_zero_len <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_rd_en     <= 1'b1;
              r_rd_addr   <= cmd_base_addr;
              r_len       <= cmd_len;
              r_res_tag   <= cmd_tag;
              r_beat      <= {LEN_WIDTH{1'b0}};
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
          end else if (w_last_beat) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
            r_drain <= DRAIN_LOAD;
          end else begin
            r_beat    <= r_beat + LEN_ONE;
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else if (r_drain == {DW{1'b0}}) begin
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
          end else begin
            r_drain <= r_drain - DW'(1);
          end
        end
        S_RESULT: begin
          // abort takes priority over a simultaneous result handshake
          if (abort) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
          end else if (res_ready) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 16'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Delay line aligning enable/clear with returned read data; abort flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_dly  <= {RD_LATENCY{1'b0}};
      r_clr_dly <= {RD_LATENCY{1'b0}};
    end else if (w_flush) begin
      r_en_dly  <= {RD_LATENCY{1'b0}};
      r_clr_dly <= {RD_LATENCY{1'b0}};
    end else begin
      r_en_dly[0]  <= r_rd_en;
      r_clr_dly[0] <= w_first_beat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_en_dly[i]  <= r_en_dly[i-1];
        r_clr_dly[i] <= r_clr_dly[i-1];
      end
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign array_enable = r_en_dly[RD_LATENCY-1];
  assign array_clear  = r_clr_dly[RD_LATENCY-1];
  assign res_valid    = r_res_valid;
  assign res_tag      = r_res_tag;
  assign busy         = r_busy;
  assign err_zero_len = r_err_zero_len;
  assign done_cnt     = r_done_cnt;

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for one MAC array instance in the PE core. Accepts a command (operand base address, reduction length, tag) over a valid/ready handshake. Issues consecutive operand-buffer reads, then drives the array's enable/clear strobes aligned to read-data return. Waits for the array pipeline to drain and presents a tagged result-valid to the downstream writeback, with backpressure.

Parameters:
ADDR_WIDTH, 10, operand buffer address width
LEN_WIDTH, 8, width of reduction-length field (beats per command)
TAG_WIDTH, 4, command tag width
RD_LATENCY, 1, operand buffer read latency in cycles (legal >= 1)
PIPE_LATENCY, 1, cycles from last array_enable to result visible at array output (legal >= 1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept command
cmd_base_addr  input  ADDR_WIDTH  first operand address
cmd_len  input  LEN_WIDTH  number of operand beats
cmd_tag  input  TAG_WIDTH  tag returned with result
abort  input  1  cancel in-flight command
rd_en  output  1  operand buffer read strobe
rd_addr  output  ADDR_WIDTH  operand buffer read address
array_enable  output  1  MAC array enable, aligned to returned operand data
array_clear  output  1  accumulator clear, first beat of a command only
res_valid  output  1  array result ready for writeback
res_ready  input  1  writeback accepts result
res_tag  output  TAG_WIDTH  tag of presented result
busy  output  1  state != IDLE
err_zero_len  output  1  one-cycle pulse: zero-length command accepted
done_cnt  output  16  completed-command counter, wraps at 2^16

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; rd_en, array_enable, array_clear, res_valid, err_zero_len, busy=0; rd_addr, res_tag, done_cnt=0; enable delay line flushed.
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE: cmd_ready=1. Handshake (cmd_valid & cmd_ready) at cycle T latches base, len, tag.
  - len=0: err_zero_len=1 at T+1; stay IDLE; no reads, no result; done_cnt unchanged.
  - Otherwise: go to ISSUE.
- ISSUE: cycles T+1..T+L.
  - rd_en=1 each cycle; rd_addr = base+i mod 2^ADDR_WIDTH for i=0..L-1, so addresses wrap.
  - After beat L-1, go to DRAIN.
- array_enable is rd_en delayed by RD_LATENCY through a shift register, asserted T+1+RD_LATENCY..T+L+RD_LATENCY.
- array_clear is high only with the first delayed beat.
- DRAIN: lasts RD_LATENCY+PIPE_LATENCY-1 cycles via down-counter, then go to RESULT.
- RESULT: res_valid=1 from cycle T+L+RD_LATENCY+PIPE_LATENCY; res_tag = latched tag.
  - res_valid and res_tag are held stable until res_ready.
  - On handshake: done_cnt+1, go to IDLE; cmd_ready=1 the following cycle. There is no same-cycle re-accept.
- cmd_ready=0 in all states except IDLE; cmd_valid is ignored outside IDLE.
- abort (sampled in ISSUE/DRAIN/RESULT): next cycle state=IDLE.
  - rd_en, array_enable, array_clear, res_valid=0 and the delay line is flushed.
  - No result is produced; done_cnt unchanged.
  - abort in IDLE has no effect.
  - abort and res_ready in the same RESULT cycle: abort wins, done_cnt unchanged.
- rst_n low mid-operation: immediate return to reset values; the in-flight command is lost.
- L = 2^LEN_WIDTH-1 is legal; the beat counter must not overflow.

Test Plan:
1. Defaults; cmd at T=0 with base=0x010, len=4, tag=3; res_ready=1 -> rd_en cycles 1-4 with rd_addr 0x010..0x013; array_enable cycles 2-5; array_clear cycle 2 only; res_valid+tag 3 at cycle 6; cmd_ready=1 at cycle 7; done_cnt=1.
2. base=0x3FE, len=4 -> rd_addr 0x3FE, 0x3FF, 0x000, 0x001; result is normal.
3. len=2, res_ready=0 for 5 cycles after res_valid -> res_valid/res_tag stable, cmd_ready=0 and second cmd_valid not accepted; on res_ready=1 handshake, cmd_ready=1 next cycle, then second command accepted.
4. len=0, tag=5 -> err_zero_len one-cycle pulse at cycle 1; no rd_en; no res_valid; cmd_ready stays 1; done_cnt unchanged.
5. len=6, abort at 2nd ISSUE beat -> rd_en and array_enable low the next cycle; no res_valid ever; cmd_ready=1 next cycle; following len=1 command completes normally.
6. RD_LATENCY=3, PIPE_LATENCY=2, len=1 at T=0 -> array_enable at cycle 4; res_valid at cycle 6. Separately, rst_n pulse during DRAIN -> all outputs at reset values asynchronously; done_cnt=0.
